adder_scheduler: RTL and testbench
==================================

# adder_scheduler

Round-robin scheduler that shares one serial 2-bit adder (`simpleadder`) between NREQ requesters. It accepts parallel 2-bit operand pairs, serializes them into the adder's start/bit-serial input protocol, and deserializes the adder's 3-bit MSB-first result. It returns each result to its requester with a completion pulse, and flags adders that fail to respond. It sits between client logic and the adder instance and is the only driver of the adder inputs.

## Interface
- NREQ, 4: number of requesters (2..8).
- TIMEOUT, 4: maximum WAIT-state samples without `add_en_i` before error.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_i  in  NREQ  request per requester; held until its gnt_o pulse.
- a_i  in  2*NREQ  operand A of requester k at [2k+1:2k].
- b_i  in  2*NREQ  operand B of requester k at [2k+1:2k].
- gnt_o  out  NREQ  one-hot, one-cycle pulse; operands of k latched at that edge.
- done_o  out  NREQ  one-hot, one-cycle pulse; result_o valid for requester k.
- result_o  out  3  sum; holds last value until next done_o.
- busy_o  out  1  high in every state except IDLE.
- err_o  out  1  sticky timeout flag, cleared only by rst.
- add_en_o, add_ina_o, add_inb_o  out  1 each  to adder en_i, ina, inb.
- add_en_i, add_out_i  in  1 each  from adder en_o, out.

## Operation
- All outputs are registered. Reset values: gnt_o=0, done_o=0, result_o=0, err_o=0, add_en_o=0, add_ina_o=0, add_inb_o=0, busy_o=1, state=DRAIN, drain counter=0, rr pointer=NREQ-1 (requester 0 highest priority first).
- DRAIN: the adder has no reset and may be mid-transaction. Stay 6 cycles, ignore add_en_i/add_out_i, then go to IDLE.
- IDLE: if any req_i is set, pick the first set index after the rr pointer (wrapping).
  - At that edge: latch a/b of the winner, gnt_o[k]=1, add_en_o=1, add_ina_o=a[1], add_inb_o=b[1], rr pointer=k, go to LSB.
- LSB: add_en_o=0, add_ina_o=a[0], add_inb_o=b[0], gnt_o=0, timeout counter=0, go to WAIT.
- WAIT: add_ina_o/add_inb_o=0.
  - If add_en_i sampled 1: shift in add_out_i as sum[2] and go to CAP1.
  - Otherwise increment the counter. When TIMEOUT samples pass without add_en_i: err_o=1, done_o[k]=1, result_o=0, go to DRAIN.
- CAP1: capture add_out_i as sum[1], go to CAP0.
- CAP0: capture add_out_i as sum[0], result_o=sum, done_o[k]=1, go to IDLE.
- Arithmetic: result = a + b, zero-extended to 3 bits, range 0..6, never truncated.
- req_i is ignored outside IDLE. A req_i still high in IDLE after done is treated as a new request.
- add_en_o is never high outside the cycle after a grant. This keeps the adder's start strobe away from its output phase.

## Timing
- T0 is the grant edge.
  - T1: adder samples MSB with en=1.
  - T2: adder samples LSB.
  - After T3: add_en_i=1 with sum[2] on add_out_i.
  - T4/T5/T6: scheduler samples sum[2]/sum[1]/sum[0].
  - T6: done_o registered; the adder returns to idle at the same edge.
- Grant-to-done latency is 6 cycles. The earliest next grant is T7, so one transaction every 7 cycles under full load.
- Nominal WAIT sampling is 3 edges (T2, T3, T4). With TIMEOUT=4, an adder that never responds flags err_o at T5.
- After rst deasserts, the first grant is no earlier than the 7th rising edge.
- Reset mid-transaction aborts without done_o. Any in-flight adder transaction completes inside DRAIN.
- Simultaneous requests: exactly one gnt_o per grant edge. The rr pointer guarantees each waiting requester a grant within NREQ transactions.

## Test plan
- Reset, then req_i[2]=1 with a=2'b11, b=2'b11 -> gnt_o[2] at first grant edge, add_en_o high exactly one cycle with ina=inb=1, done_o[2] 6 cycles later, result_o=3'b110.
- Sweep all 16 a/b pairs on requester 0 -> result_o=a+b each time, done_o pulses exactly 7 cycles apart.
- All four req_i held continuously -> grants in order 0,1,2,3,0; no requester granted twice before all others; add_en_o pulses exactly 7 cycles apart.
- Adder add_en_i forced to 0, request with a=1, b=1 -> err_o=1 at T5, done_o[k] pulse, result_o=0, DRAIN (6 cycles) before next grant, err_o remains 1.
- Assert rst at T3 of a transaction -> all outputs return to reset values immediately; no done_o; after release, a new request gives correct sum with no corruption from the aborted one.
- req_i[1] raised in the same cycle done_o[0] fires -> grant to 1 at the next IDLE edge, no lost or duplicate grant.

Source files
------------

// File: rtl/adder_scheduler_if.sv
// adder_scheduler_if: client-side bundle of the adder scheduler.
//
// Handshake: a client raises req_i[k] with its operands on a_i/b_i[2k+1:2k]
// and holds them until gnt_o[k] pulses for one cycle; the operands are
// latched at that edge. The result is returned later with a one-cycle
// done_o[k] pulse, and result_o holds that sum until the next done_o.
//
// Signals:
//   req_i    [NREQ]    request per client
//   a_i, b_i [2*NREQ]  2-bit operand pairs, client k at [2k+1:2k]
//   gnt_o    [NREQ]    one-hot grant pulse
//   done_o   [NREQ]    one-hot completion pulse
//   result_o [3]       3-bit sum
//   busy_o             scheduler not idle
//   err_o              sticky adder-timeout flag
// Modports: master = client side, slave = scheduler side.
interface adder_scheduler_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req_i;
    logic [2*NREQ-1:0] a_i;
    logic [2*NREQ-1:0] b_i;
    logic [NREQ-1:0]   gnt_o;
    logic [NREQ-1:0]   done_o;
    logic [2:0]        result_o;
    logic              busy_o;
    logic              err_o;

    modport master (
        output req_i, a_i, b_i,
        input  gnt_o, done_o, result_o, busy_o, err_o
    );

    modport slave (
        input  req_i, a_i, b_i,
        output gnt_o, done_o, result_o, busy_o, err_o
    );
endinterface

// File: rtl/adder_scheduler.sv
// adder_scheduler: round-robin arbiter sharing one bit-serial 2-bit adder
// among NREQ clients. Serializes the granted operand pair MSB-then-LSB into
// the adder, deserializes its 3-bit MSB-first sum and returns it with a
// completion pulse. An adder that does not answer within TIMEOUT samples
// sets a sticky error and the scheduler drains before serving again.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   cli (slave)          client bundle, see adder_scheduler_if
//   add_en_o             start strobe to adder en_i (MSB cycle only)
//   add_ina_o/add_inb_o  serial operand bits to the adder
//   add_en_i/add_out_i   adder output-valid and serial sum bit
//   dbg_state            current FSM state encoding
module adder_scheduler #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 4
) (
    input  logic             clk,
    input  logic             rst,
    adder_scheduler_if.slave cli,
    output logic             add_en_o,
    output logic             add_ina_o,
    output logic             add_inb_o,
    input  logic             add_en_i,
    input  logic             add_out_i,
    output logic [2:0]       dbg_state
);
    localparam int PW = $clog2(NREQ);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        DRAIN = 3'd0,
        IDLE  = 3'd1,
        LSB   = 3'd2,
        WAIT  = 3'd3,
        CAP1  = 3'd4,
        CAP0  = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      drain_q, drain_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [PW-1:0]   rr_q, rr_d;
    logic [PW-1:0]   cur_q, cur_d;
    logic [1:0]      op_a_q, op_a_d;
    logic [1:0]      op_b_q, op_b_d;
    logic [2:1]      sum_q, sum_d;
    logic [2:0]      result_q, result_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] done_q, done_d;
    logic            err_q, err_d;
    logic            en_q, en_d;
    logic            ina_q, ina_d;
    logic            inb_q, inb_d;
    logic            busy_q, busy_d;

    logic            win_found;
    logic [PW-1:0]   win_idx;

    // Round-robin pick: first set request strictly after the last winner,
    // wrapping, so the last winner has the lowest priority next time.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 1; i <= NREQ; i++) begin
            if (!win_found && cli.req_i[PW'((int'(rr_q) + i) % NREQ)]) begin
                win_found = 1'b1;
                win_idx   = PW'((int'(rr_q) + i) % NREQ);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        drain_d  = drain_q;
        tmo_d    = tmo_q;
        rr_d     = rr_q;
        cur_d    = cur_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        sum_d    = sum_q;
        result_d = result_q;
        err_d    = err_q;
        gnt_d    = '0;
        done_d   = '0;
        en_d     = 1'b0;
        ina_d    = 1'b0;
        inb_d    = 1'b0;
        case (state_q)
            // The adder has no reset; give any in-flight transaction time
            // to finish before we start a new one.
            DRAIN: begin
                if (drain_q == 3'd5) state_d = IDLE;
                else                 drain_d = drain_q + 3'd1;
            end
            IDLE: begin
                if (win_found) begin
                    op_a_d  = cli.a_i[2*int'(win_idx) +: 2];
                    op_b_d  = cli.b_i[2*int'(win_idx) +: 2];
                    gnt_d   = NREQ'(1) << win_idx;
                    en_d    = 1'b1;
                    ina_d   = op_a_d[1];
                    inb_d   = op_b_d[1];
                    rr_d    = win_idx;
                    cur_d   = win_idx;
                    state_d = LSB;
                end
            end
            LSB: begin
                ina_d   = op_a_q[0];
                inb_d   = op_b_q[0];
                tmo_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (add_en_i) begin
                    sum_d[2] = add_out_i;
                    state_d  = CAP1;
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    // Adder silent: report a zero result so the client is
                    // not left waiting, then drain.
                    err_d         = 1'b1;
                    done_d[cur_q] = 1'b1;
                    result_d      = 3'd0;
                    drain_d       = 3'd0;
                    state_d       = DRAIN;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            CAP1: begin
                sum_d[1] = add_out_i;
                state_d  = CAP0;
            end
            CAP0: begin
                result_d      = {sum_q[2], sum_q[1], add_out_i};
                done_d[cur_q] = 1'b1;
                state_d       = IDLE;
            end
            default: begin
                drain_d = 3'd0;
                state_d = DRAIN;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= DRAIN;
            drain_q  <= 3'd0;
            tmo_q    <= '0;
            rr_q     <= PW'(NREQ - 1);
            cur_q    <= '0;
            op_a_q   <= 2'd0;
            op_b_q   <= 2'd0;
            sum_q    <= 2'd0;
            result_q <= 3'd0;
            err_q    <= 1'b0;
            gnt_q    <= '0;
            done_q   <= '0;
            en_q     <= 1'b0;
            ina_q    <= 1'b0;
            inb_q    <= 1'b0;
            busy_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            drain_q  <= drain_d;
            tmo_q    <= tmo_d;
            rr_q     <= rr_d;
            cur_q    <= cur_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            sum_q    <= sum_d;
            result_q <= result_d;
            err_q    <= err_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            en_q     <= en_d;
            ina_q    <= ina_d;
            inb_q    <= inb_d;
            busy_q   <= busy_d;
        end
    end

    assign cli.gnt_o    = gnt_q;
    assign cli.done_o   = done_q;
    assign cli.result_o = result_q;
    assign cli.busy_o   = busy_q;
    assign cli.err_o    = err_q;
    assign add_en_o     = en_q;
    assign add_ina_o    = ina_q;
    assign add_inb_o    = inb_q;
    assign dbg_state    = state_q;
endmodule

// File: tb/tb_adder_scheduler.sv
// tb_adder_scheduler: directed bench for adder_scheduler with a behavioural
// bit-serial adder (no reset, MSB-first 3-bit answer starting 2 edges after
// its LSB sample). Operand/result expectations are hand-computed constants.
module tb_adder_scheduler;
    logic clk = 1'b0;
    logic rst;
    logic add_en_o, add_ina_o, add_inb_o;
    logic add_en_i, add_out_i;
    logic [2:0] dbg_state;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int done_cyc = 0;
    int prev_cyc = 0;
    int exp_sum [4] = '{1, 3, 5, 6};

    adder_scheduler_if #(.NREQ(4)) cli ();

    adder_scheduler #(.NREQ(4), .TIMEOUT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .cli       (cli),
        .add_en_o  (add_en_o),
        .add_ina_o (add_ina_o),
        .add_inb_o (add_inb_o),
        .add_en_i  (add_en_i),
        .add_out_i (add_out_i),
        .dbg_state (dbg_state)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // behavioural serial adder model
    int         ph   = 0;
    logic       ma   = 1'b0;
    logic       mb   = 1'b0;
    logic [2:0] msum = 3'd0;
    logic       m_en = 1'b0;
    logic       m_out = 1'b0;
    logic       dead = 1'b0;

    always @(posedge clk) begin
        case (ph)
            0: if (add_en_o) begin ma <= add_ina_o; mb <= add_inb_o; ph <= 1; end
            1: begin msum <= {1'b0, ma, add_ina_o} + {1'b0, mb, add_inb_o}; ph <= 2; end
            2: begin m_en <= 1'b1; m_out <= msum[2]; ph <= 3; end
            3: begin m_out <= msum[1]; ph <= 4; end
            4: begin m_out <= msum[0]; ph <= 5; end
            default: begin m_en <= 1'b0; m_out <= 1'b0; ph <= 0; end
        endcase
    end
    assign add_en_i  = dead ? 1'b0 : m_en;
    assign add_out_i = m_out;

    // driver / checker tasks
    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
        end
    endtask

    // One full transaction from an IDLE negedge to the done negedge (T6).
    task automatic txn(input int k, input logic [1:0] a, input logic [1:0] b, input logic [2:0] want);
        cli.req_i[k] = 1'b1;
        cli.a_i[2*k +: 2] = a;
        cli.b_i[2*k +: 2] = b;
        step();
        chk("gnt", 32'(cli.gnt_o), 1 << k);
        chk("add_en_t0", 32'(add_en_o), 1);
        chk("ina_t0", 32'(add_ina_o), 32'(a[1]));
        chk("inb_t0", 32'(add_inb_o), 32'(b[1]));
        cli.req_i[k] = 1'b0;
        step();
        chk("add_en_t1", 32'(add_en_o), 0);
        chk("gnt_t1", 32'(cli.gnt_o), 0);
        chk("ina_t1", 32'(add_ina_o), 32'(a[0]));
        chk("inb_t1", 32'(add_inb_o), 32'(b[0]));
        for (int t = 2; t <= 5; t++) begin
            step();
            chk("done_early", 32'(cli.done_o), 0);
            chk("add_en_late", 32'(add_en_o), 0);
        end
        step();
        chk("done", 32'(cli.done_o), 1 << k);
        chk("result", 32'(cli.result_o), 32'(want));
        done_cyc = cyc;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        cli.req_i = '0;
        cli.a_i = '0;
        cli.b_i = '0;
        step();
        step();
        // reset values
        chk("rst_gnt", 32'(cli.gnt_o), 0);
        chk("rst_done", 32'(cli.done_o), 0);
        chk("rst_result", 32'(cli.result_o), 0);
        chk("rst_err", 32'(cli.err_o), 0);
        chk("rst_busy", 32'(cli.busy_o), 1);
        chk("rst_add_en", 32'(add_en_o), 0);
        chk("rst_ina", 32'(add_ina_o), 0);
        chk("rst_inb", 32'(add_inb_o), 0);
        chk("rst_state", 32'(dbg_state), 0);

        // first request held through DRAIN: no grant before the 7th edge
        rst = 1'b0;
        cli.req_i[2] = 1'b1;
        cli.a_i[5:4] = 2'b11;
        cli.b_i[5:4] = 2'b11;
        for (int t = 1; t <= 6; t++) begin
            step();
            chk("drain_no_gnt", 32'(cli.gnt_o), 0);
        end
        chk("idle_busy", 32'(cli.busy_o), 0);
        txn(2, 2'b11, 2'b11, 3'b110);
        step();
        chk("done_pulse_end", 32'(cli.done_o), 0);
        chk("result_hold", 32'(cli.result_o), 6);

        // sweep all operand pairs on requester 0, back to back
        for (int ai = 0; ai < 4; ai++) begin
            for (int bi = 0; bi < 4; bi++) begin
                prev_cyc = done_cyc;
                txn(0, 2'(ai), 2'(bi), 3'(ai + bi));
                if (ai != 0 || bi != 0) chk("done_spacing", 32'(done_cyc - prev_cyc), 7);
            end
        end

        // adder never answers: timeout at T5, then DRAIN before next grant
        dead = 1'b1;
        cli.req_i[1] = 1'b1;
        cli.a_i[3:2] = 2'd1;
        cli.b_i[3:2] = 2'd1;
        step();
        chk("tmo_gnt", 32'(cli.gnt_o), 2);
        cli.req_i[1] = 1'b0;
        for (int t = 1; t <= 4; t++) begin
            step();
            chk("tmo_err_early", 32'(cli.err_o), 0);
            chk("tmo_done_early", 32'(cli.done_o), 0);
        end
        step();
        chk("tmo_err", 32'(cli.err_o), 1);
        chk("tmo_done", 32'(cli.done_o), 2);
        chk("tmo_result", 32'(cli.result_o), 0);
        chk("tmo_busy", 32'(cli.busy_o), 1);
        dead = 1'b0;
        cli.req_i[1] = 1'b1;
        cli.a_i[3:2] = 2'd2;
        cli.b_i[3:2] = 2'd1;
        for (int t = 6; t <= 11; t++) begin
            step();
            chk("tmo_drain_no_gnt", 32'(cli.gnt_o), 0);
            chk("err_sticky", 32'(cli.err_o), 1);
        end
        txn(1, 2'd2, 2'd1, 3'd3);
        chk("err_sticky_after", 32'(cli.err_o), 1);

        // reset between T2 and T3 of a transaction
        cli.req_i[3] = 1'b1;
        cli.a_i[7:6] = 2'd3;
        cli.b_i[7:6] = 2'd2;
        step();
        chk("abort_gnt", 32'(cli.gnt_o), 8);
        cli.req_i[3] = 1'b0;
        step();
        step();
        rst = 1'b1;
        #1;
        chk("abort_gnt0", 32'(cli.gnt_o), 0);
        chk("abort_done0", 32'(cli.done_o), 0);
        chk("abort_result0", 32'(cli.result_o), 0);
        chk("abort_err0", 32'(cli.err_o), 0);
        chk("abort_add_en0", 32'(add_en_o), 0);
        chk("abort_ina0", 32'(add_ina_o), 0);
        chk("abort_inb0", 32'(add_inb_o), 0);
        chk("abort_busy1", 32'(cli.busy_o), 1);
        chk("abort_state", 32'(dbg_state), 0);
        step();
        chk("abort_no_done", 32'(cli.done_o), 0);
        step();
        chk("abort_no_done", 32'(cli.done_o), 0);
        rst = 1'b0;
        cli.req_i[3] = 1'b1;
        cli.a_i[7:6] = 2'd1;
        cli.b_i[7:6] = 2'd2;
        for (int t = 1; t <= 6; t++) begin
            step();
            chk("abort_drain_no_gnt", 32'(cli.gnt_o), 0);
            chk("abort_drain_no_done", 32'(cli.done_o), 0);
        end
        txn(3, 2'd1, 2'd2, 3'd3);

        // all four held: rr pointer now 3, so order 0,1,2,3,0
        cli.a_i = 8'b11_10_01_00;
        cli.b_i = 8'b11_11_10_01;
        cli.req_i = 4'hF;
        for (int g = 0; g < 5; g++) begin
            step();
            chk("rr_gnt", 32'(cli.gnt_o), 1 << (g % 4));
            chk("rr_add_en", 32'(add_en_o), 1);
            if (g > 0) chk("rr_en_spacing", 32'(cyc - prev_cyc), 7);
            prev_cyc = cyc;
            for (int t = 1; t <= 5; t++) begin
                step();
                chk("rr_no_gnt", 32'(cli.gnt_o), 0);
                chk("rr_no_done", 32'(cli.done_o), 0);
            end
            step();
            chk("rr_done", 32'(cli.done_o), 1 << (g % 4));
            chk("rr_result", 32'(cli.result_o), 32'(exp_sum[g % 4]));
        end
        // new request raised in the cycle done_o[0] fires
        cli.req_i = 4'b0010;
        step();
        chk("late_gnt", 32'(cli.gnt_o), 2);
        cli.req_i = 4'b0000;
        for (int t = 1; t <= 5; t++) step();
        step();
        chk("late_done", 32'(cli.done_o), 2);
        chk("late_result", 32'(cli.result_o), 3);
        for (int t = 0; t < 8; t++) begin
            step();
            chk("no_dup_gnt", 32'(cli.gnt_o), 0);
        end
        chk("final_busy", 32'(cli.busy_o), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
